mc_ctrl: RTL

//  Multi-cycle MIPS control FSM; sequences PC, IR, GRF, ALU, immediate extender and data-memory port.

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_ctrl_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS control definitions: opcode/funct codes, extender/ALU/mux select encodings,
// controller state encoding and the decoded instruction-class record.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Extender modes; 2'b11 is reserved and never produced.
  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5
  } state_t;

  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } iclass_t;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic [1:0] eop;
    logic [1:0] alu_op;
    logic       alu_bsel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       mem_req;
    logic       mem_we;
    logic       illegal;
    logic       mem_err;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct decoder producing a one-hot instruction class.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output iclass_t    o_cls
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_RTYPE: begin
        // funct 0 (sll $0 / nop) flows through the add path; rd=$0 makes it harmless.
        case (i_funct)
          FN_SLL,
          FN_ADDU: o_cls.rtype_add = 1'b1;
          FN_SUBU: o_cls.rtype_sub = 1'b1;
          FN_JR:   o_cls.jr        = 1'b1;
          default: o_cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  o_cls.ori     = 1'b1;
      OP_LUI:  o_cls.lui     = 1'b1;
      OP_LW:   o_cls.lw      = 1'b1;
      OP_SW:   o_cls.sw      = 1'b1;
      OP_BEQ:  o_cls.beq     = 1'b1;
      OP_J:    o_cls.j       = 1'b1;
      OP_JAL:  o_cls.jal     = 1'b1;
      default: o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the datapath, runs the bounded data-memory
// handshake and counts retired instructions.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic [1:0]       eop,
  output logic [1:0]       alu_op,
  output logic             alu_bsel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           r_state;
  state_t           w_next;
  iclass_t          w_cls;
  ctl_t             w_ctl;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_timeout;

  mc_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_cls   (w_cls)
  );

  // Memory handshake: mem_req (with mem_we) is raised in S_MEM and held stable until
  // mem_ack is sampled high on a rising edge, or until WAIT_MAX ack-less cycles elapse.
  assign w_timeout = (r_state == S_MEM) && !mem_ack && (r_wait == WAIT_LIM - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_ctl    = '0;
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_RST: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_ctl.ir_we   = 1'b1;
        w_ctl.pc_we   = 1'b1;
        w_ctl.npc_sel = NPC_SEQ;
        w_next        = S_DEC;
      end
      S_DEC: begin
        if (w_cls.illegal) begin
          w_ctl.illegal = 1'b1;
          w_next        = S_FETCH;
        end else if (w_cls.j || w_cls.jal) begin
          w_ctl.pc_we   = 1'b1;
          w_ctl.npc_sel = NPC_JUMP;
          if (w_cls.jal) begin
            // PC already holds pc+4 after fetch, which is the link value.
            w_ctl.reg_we  = 1'b1;
            w_ctl.reg_dst = DST_RA;
            w_ctl.wd_sel  = WD_PC;
          end
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_cls.jr) begin
          w_ctl.pc_we   = 1'b1;
          w_ctl.npc_sel = NPC_JR;
          w_retire      = 1'b1;
          w_next        = S_FETCH;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        w_next = S_WB;
        if (w_cls.ori) begin
          w_ctl.eop      = EOP_ZERO;
          w_ctl.alu_op   = ALU_OR;
          w_ctl.alu_bsel = 1'b1;
        end else if (w_cls.lui) begin
          w_ctl.eop      = EOP_LUI;
          w_ctl.alu_op   = ALU_ADD;
          w_ctl.alu_bsel = 1'b1;
        end else if (w_cls.lw || w_cls.sw) begin
          w_ctl.eop      = EOP_SIGN;
          w_ctl.alu_op   = ALU_ADD;
          w_ctl.alu_bsel = 1'b1;
          w_next         = S_MEM;
        end else if (w_cls.beq) begin
          w_ctl.eop     = EOP_SIGN;
          w_ctl.alu_op  = ALU_SUB;
          w_ctl.pc_we   = zero;
          w_ctl.npc_sel = NPC_BR;
          w_retire      = 1'b1;
          w_next        = S_FETCH;
        end else if (w_cls.rtype_sub) begin
          w_ctl.alu_op = ALU_SUB;
        end else if (w_cls.rtype_add) begin
          w_ctl.alu_op = ALU_ADD;
        end
      end
      S_MEM: begin
        w_ctl.mem_req = 1'b1;
        w_ctl.mem_we  = w_cls.sw;
        if (mem_ack) begin
          w_retire = w_cls.sw;
          w_next   = w_cls.sw ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_ctl.mem_err = 1'b1;
          w_next        = S_FETCH;
        end
      end
      S_WB: begin
        w_ctl.reg_we = 1'b1;
        if (w_cls.rtype_add || w_cls.rtype_sub) begin
          w_ctl.reg_dst = DST_RD;
          w_ctl.wd_sel  = WD_ALU;
        end else if (w_cls.lw) begin
          w_ctl.reg_dst = DST_RT;
          w_ctl.wd_sel  = WD_MEM;
        end else begin
          w_ctl.reg_dst = DST_RT;
          w_ctl.wd_sel  = WD_ALU;
        end
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: begin
        w_next = S_RST;
      end
    endcase
  end

  // Counts consecutive ack-less S_MEM cycles; cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if ((r_state == S_MEM) && !mem_ack && !w_timeout) begin
      r_wait <= r_wait + 8'd1;
    end else begin
      r_wait <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign pc_we     = w_ctl.pc_we;
  assign npc_sel   = w_ctl.npc_sel;
  assign ir_we     = w_ctl.ir_we;
  assign eop       = w_ctl.eop;
  assign alu_op    = w_ctl.alu_op;
  assign alu_bsel  = w_ctl.alu_bsel;
  assign reg_we    = w_ctl.reg_we;
  assign reg_dst   = w_ctl.reg_dst;
  assign wd_sel    = w_ctl.wd_sel;
  assign mem_req   = w_ctl.mem_req;
  assign mem_we    = w_ctl.mem_we;
  assign illegal   = w_ctl.illegal;
  assign mem_err   = w_ctl.mem_err;
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule
